// File: rtl/fwd_hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit_pkg
//   Shared pipeline defaults for the 5-stage MIPS forwarding/hazard slice:
//   datapath width, register address width, number of result stages after
//   ID, load latency, performance counter width and the forward-select code
//   meaning "take the register file".
// ---------------------------------------------------------------------------
package fwd_hazard_unit_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned REG_AW_DEF     = 5;
    localparam int unsigned DEPTH_DEF      = 3;
    localparam int unsigned LOAD_LAT_DEF   = 1;
    localparam int unsigned CNT_W_DEF      = 16;

    // Forward-select value that picks register-file data; k+1 picks stage k.
    localparam int unsigned FWD_SEL_RF     = 0;

endpackage

// File: rtl/fwd_hazard_unit_src_sel.sv
// ---------------------------------------------------------------------------
// fwd_src_sel
//   Operand resolution for one source register of the instruction in ID.
//   Finds the youngest in-flight producer of the source, decides whether its
//   result is already available at that stage, and muxes the operand.
//
//   Ports:
//     i_src        source register number
//     i_used       source operand is actually read
//     i_rf_data    register-file read data for this source
//     i_stage_data per-stage result bus, stage k at [k*DATA_WIDTH +: DATA_WIDTH]
//     i_ent_valid  scoreboard valid bits, entry k at bit k
//     i_ent_dst    scoreboard destinations, entry k at [k*REG_AW +: REG_AW]
//     i_ent_avail  scoreboard availability stage, entry k at [k*AV_W +: AV_W]
//     o_sel        0 = register file, k+1 = stage k
//     o_opnd       resolved operand
//     o_ready      0 when the youngest producer's data is not available yet
// ---------------------------------------------------------------------------
module fwd_src_sel
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned REG_AW     = REG_AW_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned AV_W       = $clog2(DEPTH_DEF + 1),
    parameter int unsigned SEL_W      = $clog2(DEPTH_DEF + 1)
) (
    input  logic [REG_AW-1:0]           i_src,
    input  logic                        i_used,
    input  logic [DATA_WIDTH-1:0]       i_rf_data,
    input  logic [DEPTH*DATA_WIDTH-1:0] i_stage_data,
    input  logic [DEPTH-1:0]            i_ent_valid,
    input  logic [DEPTH*REG_AW-1:0]     i_ent_dst,
    input  logic [DEPTH*AV_W-1:0]       i_ent_avail,
    output logic [SEL_W-1:0]            o_sel,
    output logic [DATA_WIDTH-1:0]       o_opnd,
    output logic                        o_ready
);

    logic w_found;
    logic w_live;

    // r0 is hard-wired zero and an unread source never creates a dependency.
    assign w_live = i_used && (i_src != '0);

    always_comb begin
        w_found = 1'b0;
        o_sel   = SEL_W'(FWD_SEL_RF);
        o_opnd  = i_rf_data;
        o_ready = 1'b1;
        // Ascending scan with a found flag: the lowest stage index is the
        // youngest producer and must shadow any older writer of the same reg.
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!w_found && w_live && i_ent_valid[k] &&
                (i_ent_dst[k*REG_AW +: REG_AW] == i_src)) begin
                w_found = 1'b1;
                if (k >= 32'(i_ent_avail[k*AV_W +: AV_W])) begin
                    o_sel  = SEL_W'(k + 1);
                    o_opnd = i_stage_data[k*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    o_ready = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//   Forwarding and load-use hazard unit for the 5-stage MIPS pipeline.
//   Tracks in-flight destination registers in a DEPTH-entry scoreboard that
//   shifts every cycle with the pipeline, resolves both ID source operands,
//   raises a stall when a producer's data is not yet available, and keeps
//   saturating stall/forward event counters.
//
//   Ports:
//     clk_87, rst_87              clock (rising edge), async active-high reset
//     issue_valid_87              ID holds a valid instruction
//     issue_wr_87, issue_load_87  instruction writes a register / is a load
//     issue_dst_87                destination register
//     rs_87, rt_87                source registers
//     rs_used_87, rt_used_87      source operands actually read
//     rf_data_a_87, rf_data_b_87  register-file read data
//     stage_data_87               per-stage results, stage k at [k*DW +: DW]
//     flush_87                    squash the issuing instruction
//     stall_87                    hold PC and IF/ID, bubble into EX
//     fwd_sel_a_87, fwd_sel_b_87  0 = register file, k+1 = stage k
//     opnd_a_87, opnd_b_87        resolved operands
//     wb_en_87, wb_reg_87         oldest entry writes the register file
//     stall_cnt_87, fwd_cnt_87    saturating event counters
// ---------------------------------------------------------------------------
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned REG_AW     = REG_AW_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned LOAD_LAT   = LOAD_LAT_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                          clk_87,
    input  logic                          rst_87,
    input  logic                          issue_valid_87,
    input  logic                          issue_wr_87,
    input  logic                          issue_load_87,
    input  logic [REG_AW-1:0]             issue_dst_87,
    input  logic [REG_AW-1:0]             rs_87,
    input  logic [REG_AW-1:0]             rt_87,
    input  logic                          rs_used_87,
    input  logic                          rt_used_87,
    input  logic [DATA_WIDTH-1:0]         rf_data_a_87,
    input  logic [DATA_WIDTH-1:0]         rf_data_b_87,
    input  logic [DEPTH*DATA_WIDTH-1:0]   stage_data_87,
    input  logic                          flush_87,
    output logic                          stall_87,
    output logic [$clog2(DEPTH+1)-1:0]    fwd_sel_a_87,
    output logic [$clog2(DEPTH+1)-1:0]    fwd_sel_b_87,
    output logic [DATA_WIDTH-1:0]         opnd_a_87,
    output logic [DATA_WIDTH-1:0]         opnd_b_87,
    output logic                          wb_en_87,
    output logic [REG_AW-1:0]             wb_reg_87,
    output logic [CNT_W-1:0]              stall_cnt_87,
    output logic [CNT_W-1:0]              fwd_cnt_87
);

    localparam int unsigned AV_W  = $clog2(DEPTH + 1);
    localparam int unsigned SEL_W = $clog2(DEPTH + 1);

    // Scoreboard, entry k packed at index k of each flattened vector.
    logic [DEPTH-1:0]        r_valid;
    logic [DEPTH*REG_AW-1:0] r_dst;
    logic [DEPTH*AV_W-1:0]   r_avail;

    logic [CNT_W-1:0]        r_stall_cnt;
    logic [CNT_W-1:0]        r_fwd_cnt;

    logic                    w_ready_a;
    logic                    w_ready_b;
    logic                    w_issue_ok;
    logic                    w_ent0_valid;
    logic [AV_W-1:0]         w_ent0_avail;
    logic                    w_fwd_event;

    fwd_src_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_AW     (REG_AW),
        .DEPTH      (DEPTH),
        .AV_W       (AV_W),
        .SEL_W      (SEL_W)
    ) u_sel_a (
        .i_src        (rs_87),
        .i_used       (rs_used_87),
        .i_rf_data    (rf_data_a_87),
        .i_stage_data (stage_data_87),
        .i_ent_valid  (r_valid),
        .i_ent_dst    (r_dst),
        .i_ent_avail  (r_avail),
        .o_sel        (fwd_sel_a_87),
        .o_opnd       (opnd_a_87),
        .o_ready      (w_ready_a)
    );

    fwd_src_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_AW     (REG_AW),
        .DEPTH      (DEPTH),
        .AV_W       (AV_W),
        .SEL_W      (SEL_W)
    ) u_sel_b (
        .i_src        (rt_87),
        .i_used       (rt_used_87),
        .i_rf_data    (rf_data_b_87),
        .i_stage_data (stage_data_87),
        .i_ent_valid  (r_valid),
        .i_ent_dst    (r_dst),
        .i_ent_avail  (r_avail),
        .o_sel        (fwd_sel_b_87),
        .o_opnd       (opnd_b_87),
        .o_ready      (w_ready_b)
    );

    // Flush wins over stall: a squashed instruction never needs its operands.
    assign stall_87     = issue_valid_87 && !(w_ready_a && w_ready_b) && !flush_87;
    assign w_issue_ok   = issue_valid_87 && !stall_87 && !flush_87;
    assign w_ent0_valid = w_issue_ok && issue_wr_87 && (issue_dst_87 != '0);
    assign w_ent0_avail = issue_load_87 ? AV_W'(LOAD_LAT) : '0;
    assign w_fwd_event  = w_issue_ok &&
                          ((fwd_sel_a_87 != '0) || (fwd_sel_b_87 != '0));

    assign wb_en_87     = r_valid[DEPTH-1];
    assign wb_reg_87    = r_dst[(DEPTH-1)*REG_AW +: REG_AW];
    assign stall_cnt_87 = r_stall_cnt;
    assign fwd_cnt_87   = r_fwd_cnt;

    // Downstream stages never stall, so the scoreboard shifts every cycle;
    // a stalled or flushed issue simply inserts a bubble at entry 0.
    always_ff @(posedge clk_87 or posedge rst_87) begin
        if (rst_87) begin
            r_valid <= '0;
            r_dst   <= '0;
            r_avail <= '0;
        end else begin
            for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
                r_valid[k]                 <= r_valid[k-1];
                r_dst[k*REG_AW +: REG_AW]  <= r_dst[(k-1)*REG_AW +: REG_AW];
                r_avail[k*AV_W +: AV_W]    <= r_avail[(k-1)*AV_W +: AV_W];
            end
            r_valid[0]          <= w_ent0_valid;
            r_dst[0 +: REG_AW]  <= issue_dst_87;
            r_avail[0 +: AV_W]  <= w_ent0_avail;
        end
    end

    always_ff @(posedge clk_87 or posedge rst_87) begin
        if (rst_87) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (stall_87 && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_fwd_event && (r_fwd_cnt != '1)) begin
                r_fwd_cnt <= r_fwd_cnt + 1'b1;
            end
        end
    end

endmodule
